// File: rtl/fsbn_master.sv
// fsbn_master: host-to-FSB bridge master with CMD/ADDR latch reuse and incrementing bursts.
// Optional macro FSBN_MASTER_TIMEOUT_EN adds a wait-state timeout that ends in an error response.
//
// state | meaning
// IDLE  | no transfer, hready=1
// CMD   | page-extension frame, drives haddr[31:24] on aah
// ADDR  | address frame, latches haddr[23:8]
// TURN  | bus turnaround before read data
// DATA  | cs_n low, waits for rdy_n
// RESP  | transfer complete, hready=1
// ERR1  | timeout, first error cycle (hready=0)
// ERR2  | timeout, second error cycle (hready=1)
module fsbn_master #(
    parameter int AW        = 24,
    parameter int BURST_MAX = 16,
    parameter int WAIT_W    = 8
) (
    input  logic          hclk,
    input  logic          hreset,
    input  logic          hsel,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic          hburst,
    input  logic [AW-1:0] haddr,
    input  logic [7:0]    hwdata,
    output logic [7:0]    hrdata,
    output logic          hready,
    output logic          hresp,
    output logic          ale_n,
    output logic          cs_n,
    output logic          cmd_n,
    output logic          wr_n,
    output logic          typ,
    input  logic          rdy_n,
    input  logic          irq_n,
    output logic          ad_oe,
    output logic [7:0]    ad_out,
    input  logic [7:0]    ad_in,
    output logic [7:0]    aah,
    output logic          fsb_irq
);

    localparam int BW = $clog2(BURST_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_TURN, S_DATA, S_RESP, S_ERR1, S_ERR2
    } state_t;

    state_t        state, state_nxt, entry_state, post_cmd_state;
    logic [31:0]   addr;
    logic          valid, is_nonseq, is_seq, hi_hit, mid_hit, burst_hit, beat_max;
    logic [7:0]    hi8;
    logic          hi8_vld;
    logic [15:0]   mid16;
    logic          mid16_vld;
    logic [BW-1:0] beat_cnt;
    logic [1:0]    irq_sync;
    logic          wait_expired;

    assign addr      = 32'(haddr);
    assign valid     = hsel & htrans[1];
    assign is_nonseq = (htrans == 2'b10);
    assign is_seq    = (htrans == 2'b11);
    assign hi_hit    = (AW != 32) || (hi8_vld && (hi8 == addr[31:24]));
    assign mid_hit   = mid16_vld && (mid16 == addr[23:8]);
    assign burst_hit = valid && is_seq && hburst && hi_hit && mid_hit;
    assign beat_max  = (beat_cnt >= BW'(BURST_MAX));
    assign fsb_irq   = irq_sync[1];

    always_comb begin
        post_cmd_state = S_DATA;
        if (!mid_hit)
            post_cmd_state = S_ADDR;
        else if (!hwrite)
            post_cmd_state = S_TURN;
        entry_state = hi_hit ? post_cmd_state : S_CMD;
    end

`ifdef FSBN_MASTER_TIMEOUT_EN
    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            wait_cnt <= '0;
        else if (state == S_DATA && rdy_n)
            wait_cnt <= wait_cnt + 1'b1;
        else
            wait_cnt <= '0;
    end

    // The counter reaches all-ones on the same edge that enters ERR1.
    assign wait_expired = (state == S_DATA) && rdy_n && (wait_cnt == ~WAIT_W'(1));
    assign hresp        = (state == S_ERR1) || (state == S_ERR2);
`else
    assign wait_expired = 1'b0;
    assign hresp        = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        ale_n     = 1'b1;
        cs_n      = 1'b1;
        cmd_n     = 1'b1;
        wr_n      = 1'b1;
        typ       = 1'b0;
        ad_oe     = 1'b0;
        ad_out    = 8'h00;
        aah       = 8'h00;
        hready    = 1'b0;
        case (state)
            S_IDLE: begin
                hready = 1'b1;
                if (valid)
                    state_nxt = (burst_hit && !beat_max) ? S_DATA : entry_state;
            end
            S_CMD: begin
                cmd_n     = 1'b0;
                ad_oe     = 1'b1;
                aah       = addr[31:24];
                state_nxt = post_cmd_state;
            end
            S_ADDR: begin
                ale_n     = 1'b0;
                ad_oe     = 1'b1;
                ad_out    = addr[15:8];
                aah       = addr[23:16];
                state_nxt = hwrite ? S_DATA : S_TURN;
            end
            S_TURN: state_nxt = S_DATA;
            S_DATA: begin
                cs_n   = 1'b0;
                wr_n   = ~hwrite;
                ad_oe  = hwrite;
                ad_out = hwdata;
                aah    = addr[7:0];
                typ    = hburst;
                if (!rdy_n)
                    state_nxt = S_RESP;
                else if (wait_expired)
                    state_nxt = S_ERR1;
            end
            S_RESP: begin
                hready = 1'b1;
                if (!valid)
                    state_nxt = S_IDLE;
                else if (burst_hit)
                    state_nxt = beat_max ? S_IDLE : S_DATA;
                else
                    state_nxt = entry_state;
                cs_n = (state_nxt != S_DATA);
            end
            S_ERR1:  state_nxt = S_ERR2;
            S_ERR2: begin
                hready    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state     <= S_IDLE;
            hrdata    <= 8'h00;
            hi8       <= 8'h00;
            hi8_vld   <= 1'b0;
            mid16     <= 16'h0000;
            mid16_vld <= 1'b0;
            beat_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CMD) begin
                hi8     <= addr[31:24];
                hi8_vld <= 1'b1;
            end
            if (state == S_ADDR) begin
                mid16     <= addr[23:8];
                mid16_vld <= 1'b1;
            end
            if (state == S_ERR1) begin
                hi8_vld   <= 1'b0;
                mid16_vld <= 1'b0;
            end
            if (state == S_DATA && !rdy_n && !hwrite)
                hrdata <= ad_in;
            // A full burst frees the counter in RESP whether or not the burst continues.
            if ((state == S_IDLE || state == S_RESP) && valid && is_nonseq)
                beat_cnt <= '0;
            else if (state == S_RESP && beat_max)
                beat_cnt <= '0;
            else if (state == S_DATA && !rdy_n)
                beat_cnt <= beat_cnt + 1'b1;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)
            irq_sync <= 2'b00;
        else
            irq_sync <= {irq_sync[0], ~irq_n};
    end

endmodule

// File: tb/tb_fsbn_master.sv
// Testbench for fsbn_master: a transaction-level model predicts the FSB frame sequence per transfer.
// Two instances (AW=24/BURST_MAX=4/WAIT_W=4 and AW=32 defaults) share stimulus; sel picks the checked one.
module tb_fsbn_master;

    localparam int F_HR = 0, F_CMD = 1, F_ADDR = 2, F_TURN = 3, F_DATA = 4, F_ERR1 = 5, F_ERR2 = 6;

    logic        hclk = 1'b0;
    logic        hreset = 1'b1;
    logic        hsel = 1'b0, hwrite = 1'b0, hburst = 1'b0;
    logic [1:0]  htrans = 2'b00;
    logic [31:0] haddr = 32'h0;
    logic [7:0]  hwdata = 8'h00, ad_in = 8'h00;
    logic        rdy_n = 1'b1, irq_n = 1'b1;
    logic        sel = 1'b0;

    logic [7:0] a_hrdata, a_ad_out, a_aah, b_hrdata, b_ad_out, b_aah;
    logic a_hready, a_hresp, a_ale_n, a_cs_n, a_cmd_n, a_wr_n, a_typ, a_ad_oe, a_fsb_irq;
    logic b_hready, b_hresp, b_ale_n, b_cs_n, b_cmd_n, b_wr_n, b_typ, b_ad_oe, b_fsb_irq;

    logic [7:0] o_hrdata, o_ad_out, o_aah;
    logic o_hready, o_hresp, o_ale_n, o_cs_n, o_cmd_n, o_wr_n, o_typ, o_ad_oe, o_fsb_irq;

    int total = 0;
    int bad = 0;

    // Reference model: what the FSB slave has been told so far.
    logic [7:0]  m_hi;
    logic        m_hi_v;
    logic [15:0] m_mid;
    logic        m_mid_v;
    logic [7:0]  m_hrdata;
    int          m_beats;
    logic        m_pend;
    logic        m_prev_resp;

    always #5 hclk = ~hclk;

    fsbn_master #(.AW(24), .BURST_MAX(4), .WAIT_W(4)) u24 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hburst(hburst), .haddr(haddr[23:0]), .hwdata(hwdata), .hrdata(a_hrdata),
        .hready(a_hready), .hresp(a_hresp), .ale_n(a_ale_n), .cs_n(a_cs_n), .cmd_n(a_cmd_n),
        .wr_n(a_wr_n), .typ(a_typ), .rdy_n(rdy_n), .irq_n(irq_n), .ad_oe(a_ad_oe),
        .ad_out(a_ad_out), .ad_in(ad_in), .aah(a_aah), .fsb_irq(a_fsb_irq)
    );

    fsbn_master #(.AW(32), .BURST_MAX(16), .WAIT_W(8)) u32 (
        .hclk(hclk), .hreset(hreset), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hburst(hburst), .haddr(haddr), .hwdata(hwdata), .hrdata(b_hrdata),
        .hready(b_hready), .hresp(b_hresp), .ale_n(b_ale_n), .cs_n(b_cs_n), .cmd_n(b_cmd_n),
        .wr_n(b_wr_n), .typ(b_typ), .rdy_n(rdy_n), .irq_n(irq_n), .ad_oe(b_ad_oe),
        .ad_out(b_ad_out), .ad_in(ad_in), .aah(b_aah), .fsb_irq(b_fsb_irq)
    );

    assign o_hrdata  = sel ? b_hrdata  : a_hrdata;
    assign o_ad_out  = sel ? b_ad_out  : a_ad_out;
    assign o_aah     = sel ? b_aah     : a_aah;
    assign o_hready  = sel ? b_hready  : a_hready;
    assign o_hresp   = sel ? b_hresp   : a_hresp;
    assign o_ale_n   = sel ? b_ale_n   : a_ale_n;
    assign o_cs_n    = sel ? b_cs_n    : a_cs_n;
    assign o_cmd_n   = sel ? b_cmd_n   : a_cmd_n;
    assign o_wr_n    = sel ? b_wr_n    : a_wr_n;
    assign o_typ     = sel ? b_typ     : a_typ;
    assign o_ad_oe   = sel ? b_ad_oe   : a_ad_oe;
    assign o_fsb_irq = sel ? b_fsb_irq : a_fsb_irq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify();
        if (!o_cmd_n) return F_CMD;
        if (!o_ale_n) return F_ADDR;
        if (!o_hready && o_hresp) return F_ERR1;
        if (o_hready && o_hresp) return F_ERR2;
        if (!o_hready && !o_cs_n) return F_DATA;
        if (!o_hready) return F_TURN;
        return F_HR;
    endfunction

    task automatic model_reset();
        m_hi_v = 1'b0; m_mid_v = 1'b0; m_hi = 8'h00; m_mid = 16'h0000;
        m_hrdata = 8'h00; m_beats = 0; m_pend = 1'b0; m_prev_resp = 1'b0;
    endtask

    task automatic apply_reset();
        hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hburst = 1'b0;
        rdy_n = 1'b1; irq_n = 1'b1;
        @(negedge hclk);
        @(negedge hclk);
        chk("rst_strobes", {o_ale_n, o_cs_n, o_cmd_n, o_wr_n}, 4'b1111);
        chk("rst_typ_oe", {o_typ, o_ad_oe}, 2'b00);
        chk("rst_ad_out", o_ad_out, 8'h00);
        chk("rst_aah", o_aah, 8'h00);
        chk("rst_hrdata", o_hrdata, 8'h00);
        chk("rst_hready_hresp", {o_hready, o_hresp}, 2'b10);
        chk("rst_fsb_irq", o_fsb_irq, 1'b0);
        hreset = 1'b0;
        model_reset();
    endtask

    task automatic idle_cycles(input int n);
        hsel = 1'b0; htrans = 2'b00; rdy_n = 1'b1;
        repeat (n) @(negedge hclk);
        m_prev_resp = 1'b0;
        m_pend = 1'b0;
    endtask

    // Called just after a negedge while the DUT sits in IDLE or RESP; returns at the
    // negedge of this transfer's RESP (or ERR2).
    task automatic do_xfer(input logic [31:0] a, input logic w, input logic [1:0] tr,
                           input logic b, input int wait_n, input logic [7:0] d);
        int q[$];
        logic hi_hit, mid_hit, direct, to;
        int lim, ndata, k;
        logic [7:0] exp_rd;
        hi_hit  = !sel || (m_hi_v && m_hi == a[31:24]);
        mid_hit = m_mid_v && m_mid == a[23:8];
        if (tr == 2'b10) begin m_beats = 0; m_pend = 1'b0; end
        direct = (tr == 2'b11) && b && hi_hit && mid_hit;
        if (direct) begin
            if (m_pend) q.push_back(F_HR);
        end else begin
            if (!hi_hit) q.push_back(F_CMD);
            if (!mid_hit) q.push_back(F_ADDR);
            if (!w) q.push_back(F_TURN);
        end
        m_pend = 1'b0;
        lim = sel ? 255 : 15;
`ifdef FSBN_MASTER_TIMEOUT_EN
        to = (wait_n >= lim);
`else
        to = 1'b0;
`endif
        ndata = to ? lim : wait_n + 1;
        repeat (ndata) q.push_back(F_DATA);
        if (to) begin q.push_back(F_ERR1); q.push_back(F_ERR2); end
        else q.push_back(F_HR);
        exp_rd = w ? m_hrdata : d;

        hsel = 1'b1; htrans = tr; hwrite = w; hburst = b; haddr = a;
        hwdata = w ? d : 8'($urandom); ad_in = w ? 8'($urandom) : d; rdy_n = 1'b1;
        #1;
        chk("acc_hready", o_hready, 1'b1);
        chk("acc_cs_n", o_cs_n, !(m_prev_resp && q[0] == F_DATA));
        k = 0;
        for (int i = 0; i < q.size(); i++) begin
            @(negedge hclk);
            chk("frame_kind", classify(), q[i]);
            rdy_n = 1'b1;
            case (q[i])
                F_CMD: begin
                    chk("cmd_ad_out", {o_ad_oe, o_ad_out}, {1'b1, 8'h00});
                    chk("cmd_aah", o_aah, a[31:24]);
                end
                F_ADDR: begin
                    chk("addr_ad_out", {o_ad_oe, o_ad_out}, {1'b1, a[15:8]});
                    chk("addr_aah", o_aah, a[23:16]);
                end
                F_TURN: chk("turn_ad_oe", o_ad_oe, 1'b0);
                F_DATA: begin
                    chk("data_ctl", {o_wr_n, o_ad_oe, o_typ}, {!w, w, b});
                    chk("data_aah", o_aah, a[7:0]);
                    if (w) chk("data_ad_out", o_ad_out, d);
                    rdy_n = (k < wait_n) ? 1'b1 : 1'b0;
                    k++;
                end
                F_HR: begin
                    if (i == q.size() - 1) begin
                        chk("resp_hresp", o_hresp, 1'b0);
                        chk("resp_hrdata", o_hrdata, exp_rd);
                    end else begin
                        chk("release_cs_n", o_cs_n, 1'b1);
                    end
                end
                default: ;
            endcase
        end
        if (q.size() > 0 && (q[0] == F_CMD)) begin m_hi = a[31:24]; m_hi_v = 1'b1; end
        foreach (q[i]) if (q[i] == F_ADDR) begin m_mid = a[23:8]; m_mid_v = 1'b1; end
        if (to) begin
            m_hi_v = 1'b0; m_mid_v = 1'b0; m_prev_resp = 1'b0;
        end else begin
            m_hrdata = exp_rd;
            m_beats++;
            if (m_beats == (sel ? 16 : 4)) begin m_beats = 0; m_pend = 1'b1; end
            m_prev_resp = 1'b1;
        end
    endtask

    initial begin
        logic [15:0] pg;
        logic [7:0]  hi;
        int          r;
        logic        found;

        sel = 1'b0;
        apply_reset();

        do_xfer(32'h0012_3456, 1'b0, 2'b10, 1'b0, 1, 8'hA5);
        do_xfer(32'h0012_34FF, 1'b1, 2'b10, 1'b0, 0, 8'h5C);

        idle_cycles(1);
        irq_n = 1'b0;
        @(negedge hclk); chk("irq_rise_1", o_fsb_irq, 1'b0);
        @(negedge hclk); chk("irq_rise_2", o_fsb_irq, 1'b1);
        irq_n = 1'b1;
        @(negedge hclk); chk("irq_fall_1", o_fsb_irq, 1'b1);
        @(negedge hclk); chk("irq_fall_2", o_fsb_irq, 1'b0);

        for (int n = 0; n < 24; n++) begin
            r  = $urandom_range(0, 2);
            pg = (r == 0) ? 16'h1234 : (r == 1) ? 16'h1235 : 16'h00AB;
            do_xfer({8'h00, pg, 8'($urandom)}, 1'($urandom), 2'b10, 1'b0,
                    $urandom_range(0, 3), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle_cycles(1);
        end
        idle_cycles(2);

        do_xfer(32'h0000_0410, 1'b0, 2'b10, 1'b1, 0, 8'($urandom));
        for (int n = 1; n < 6; n++)
            do_xfer(32'h0000_0410 + n, 1'b0, 2'b11, 1'b1, $urandom_range(0, 2), 8'($urandom));

        do_xfer(32'h0000_04FE, 1'b0, 2'b10, 1'b1, 0, 8'($urandom));
        do_xfer(32'h0000_04FF, 1'b0, 2'b11, 1'b1, 1, 8'($urandom));
        do_xfer(32'h0000_0500, 1'b0, 2'b11, 1'b1, 0, 8'($urandom));
        idle_cycles(1);

        do_xfer(32'h0000_0520, 1'b0, 2'b10, 1'b0, 40, 8'($urandom));
        idle_cycles(1);
        do_xfer(32'h0000_0521, 1'b0, 2'b10, 1'b0, 0, 8'($urandom));
        idle_cycles(1);

        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b0; hburst = 1'b0; haddr = 32'h0000_0777;
        rdy_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge hclk);
            if (!o_cs_n && !o_hready) found = 1'b1;
        end
        chk("rst_reach_data", found, 1'b1);
        #2 hreset = 1'b1;
        #1 chk("rst_cs_n_async", {o_cs_n, o_hready}, 2'b11);
        @(negedge hclk);
        hreset = 1'b0; hsel = 1'b0; htrans = 2'b00;
        model_reset();
        @(negedge hclk);
        do_xfer(32'h0000_0777, 1'b0, 2'b10, 1'b0, 0, 8'($urandom));
        idle_cycles(1);

        sel = 1'b1;
        apply_reset();
        do_xfer(32'h0100_0000, 1'b0, 2'b10, 1'b0, 0, 8'($urandom));
        do_xfer(32'h0200_0000, 1'b0, 2'b10, 1'b0, 1, 8'($urandom));
        for (int n = 0; n < 10; n++) begin
            hi = 8'($urandom_range(1, 3));
            pg = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'h4455;
            do_xfer({hi, pg, 8'($urandom)}, 1'($urandom), 2'b10, 1'b0,
                    $urandom_range(0, 2), 8'($urandom));
        end
        idle_cycles(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsbn_master.md
FSBN_MASTER -- requirements
Module: fsbn_master

Interface
REQ-001 SHALL have parameter AW, default 24, meaning host address width (24 or 32); AW=32 enables the page-extension CMD frame.
REQ-002 SHALL have parameter BURST_MAX, default 16, meaning max beats (1..256) per FSB burst before a forced cs_n release.
REQ-003 SHALL have parameter WAIT_W, default 8, meaning width of the wait-state timeout counter.
REQ-004 SHALL have ports: hclk in 1, sole clock; hreset in 1, asynchronous active-high reset.
REQ-005 SHALL have host ports: hsel in 1; htrans in 2 (2=NONSEQ, 3=SEQ, others idle); hwrite in 1; hburst in 1 (1=incrementing); haddr in AW; hwdata in 8; hrdata out 8; hready out 1; hresp out 1 (1=ERROR).
REQ-006 SHALL have FSB ports: ale_n, cs_n, cmd_n, wr_n, typ out 1 each; rdy_n, irq_n in 1 each; ad_oe out 1 (1=drive AD); ad_out out 8; ad_in in 8; aah out 8; fsb_irq out 1.
REQ-007 SHALL take all host inputs as held stable while hready=0.

Function
REQ-008 SHALL define valid = hsel & htrans[1].
REQ-009 SHALL implement states IDLE, CMD, ADDR, TURN, DATA, RESP, ERR1, ERR2.
REQ-010 In IDLE/RESP, on valid, SHALL go to CMD if AW=32 and (hi8 latch invalid or != haddr[31:24]); else ADDR if mid16 latch invalid or != haddr[23:8]; else TURN if read; else DATA.
REQ-011 CMD (1 cycle): cmd_n=0, ad_oe=1, ad_out=8'h00, aah=haddr[31:24]; latch hi8; next ADDR/TURN/DATA per REQ-010 rules.
REQ-012 ADDR (1 cycle): ale_n=0, ad_oe=1, ad_out=haddr[15:8], aah=haddr[23:16]; latch mid16; next TURN if read, else DATA.
REQ-013 TURN (1 cycle): all strobes high, ad_oe=0; next DATA.
REQ-014 DATA: cs_n=0, wr_n=!hwrite, ad_oe=hwrite, ad_out=hwdata, aah=haddr[7:0], typ=hburst; held until rdy_n sampled low.
REQ-015 On the edge sampling rdy_n=0 in DATA, SHALL capture ad_in into hrdata (reads only) and enter RESP.
REQ-016 RESP (1 cycle): hready=1, hresp=0; strobes high, except cs_n stays 0 when next state is DATA.
REQ-017 From RESP, if valid & htrans=SEQ & hburst & beat count < BURST_MAX & both latches hit, SHALL enter DATA directly without ADDR/TURN; otherwise follow REQ-010.
REQ-018 Beat counter SHALL reset on each NONSEQ and on reaching BURST_MAX; at BURST_MAX the next beat SHALL return to IDLE for one cycle (cs_n=1) before DATA.
REQ-019 A SEQ beat crossing a 256-byte page SHALL emit an ADDR frame (plus TURN for reads).
REQ-020 In IDLE, hready=1 and hresp=0; hready=0 in CMD, ADDR, TURN, DATA.
REQ-021 fsb_irq SHALL be !irq_n through a two-flop synchroniser.
REQ-022 Outputs not specified for a state SHALL be strobes high, ad_oe=0, typ=0.

Reset
REQ-023 On hreset=1 SHALL asynchronously enter IDLE: ale_n=cs_n=cmd_n=wr_n=1, typ=0, ad_oe=0, ad_out=0, aah=0, hrdata=0, hready=1, hresp=0, fsb_irq=0, latches invalid, counters 0.
REQ-024 Reset mid-DATA SHALL deassert cs_n immediately; the first transfer after reset SHALL emit ADDR (and CMD if AW=32).

Configuration
REQ-025 Macro FSBN_MASTER_TIMEOUT_EN: when defined, a WAIT_W counter SHALL count DATA cycles with rdy_n=1; at all-ones SHALL go ERR1 (hready=0, hresp=1), then ERR2 (hready=1, hresp=1), then IDLE, invalidating both latches.
REQ-026 Without FSBN_MASTER_TIMEOUT_EN, DATA SHALL wait indefinitely, hresp SHALL be constant 0, ERR1/ERR2 unreachable.

Verification
REQ-027 Reset, single read 0x123456, rdy_n low 2nd DATA cycle, ad_in=0xA5 -> ADDR(ad_out=0x34, aah=0x12), TURN, 2 DATA cycles, RESP hrdata=0xA5.
REQ-028 Second write 0x1234FF after REQ-027 -> no ADDR, DATA with aah=0xFF, wr_n=0, ad_oe=1.
REQ-029 BURST_MAX=4, 6-beat incr read -> typ=1, cs_n high exactly one cycle after beat 4, no ADDR frame.
REQ-030 AW=32, access 0x01000000 then 0x02000000 -> CMD frame each with aah=0x01 then 0x02, ad_out=0x00.
REQ-031 Macro defined, WAIT_W=4, rdy_n held high -> ERR1 after 15 wait cycles, ERR2 hready=1 hresp=1; next access re-emits ADDR.
